// File: rtl/ssa_digit_conv_if.sv
// rtl/ssa_digit_conv_if.sv - operand/result handshake bundle for the digit-convolution stage
// Ports (signals):
//   in_valid/in_ready  operand pair handshake (a, b)
//   out_valid/out_ready result handshake (coef)
//   master modport: upstream/downstream side; slave modport: the stage itself
interface ssa_digit_conv_if #(
    parameter int OP_W  = 8,
    parameter int BUS_W = 96
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] coef;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, coef
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, coef
    );
endinterface

// File: rtl/ssa_digit_conv.sv
// rtl/ssa_digit_conv.sv - sequential length-8 cyclic digit convolution, one MAC per cycle
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   conv_if  slave side of ssa_digit_conv_if: in_valid/in_ready/a/b in,
//            out_valid/out_ready/coef out (coef k at [9k+8:9k], upper bits 0)
module ssa_digit_conv #(
    parameter int DIG_W  = 2,
    parameter int N_DIG  = 4,
    parameter int N_COEF = 8,
    parameter int COEF_W = 9,
    parameter int BUS_W  = 96
) (
    input  logic             clk,
    input  logic             rst_n,
    ssa_digit_conv_if.slave  conv_if
);
    localparam int OP_W   = DIG_W * N_DIG;
    localparam int CNT_W  = $clog2(N_DIG);
    localparam int IDX_W  = $clog2(N_COEF);
    localparam int PROD_W = 2 * DIG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  i_q, i_d;
    logic [CNT_W-1:0]  j_q, j_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic [COEF_W-1:0] acc_q [N_COEF];
    logic [COEF_W-1:0] acc_d [N_COEF];

    logic [DIG_W-1:0]  a_dig [N_DIG];
    logic [DIG_W-1:0]  b_dig [N_DIG];
    logic [PROD_W-1:0] prod;
    logic [IDX_W-1:0]  idx;
    logic [BUS_W-1:0]  coef_bus;

    for (genvar k = 0; k < N_DIG; k++) begin : g_dig
        assign a_dig[k] = a_q[k*DIG_W +: DIG_W];
        assign b_dig[k] = b_q[k*DIG_W +: DIG_W];
    end

    assign prod = PROD_W'(a_dig[i_q]) * PROD_W'(b_dig[j_q]);
    // i+j tops out at 2*(N_DIG-1) < N_COEF, so no modular wrap is needed.
    assign idx  = IDX_W'(i_q) + IDX_W'(j_q);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (conv_if.in_valid) begin
                    a_d     = conv_if.a;
                    b_d     = conv_if.b;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = CALC;
                    for (int k = 0; k < N_COEF; k++) begin
                        acc_d[k] = '0;
                    end
                end
            end
            CALC: begin
                acc_d[idx] = acc_q[idx] + COEF_W'(prod);
                if (j_q == CNT_W'(N_DIG - 1)) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                    if (i_q == CNT_W'(N_DIG - 1)) begin
                        state_d = DONE;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                if (conv_if.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            for (int k = 0; k < N_COEF; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    // Accumulators are only cleared on the next accept, so coef keeps the
    // last result after the output handshake.
    always_comb begin
        coef_bus = '0;
        for (int k = 0; k < N_COEF; k++) begin
            coef_bus[k*COEF_W +: COEF_W] = acc_q[k];
        end
    end

    assign conv_if.in_ready  = (state_q == IDLE);
    assign conv_if.out_valid = (state_q == DONE);
    assign conv_if.coef      = coef_bus;
endmodule

// File: tb/tb_ssa_digit_conv.sv
// tb/tb_ssa_digit_conv.sv - self-checking bench for ssa_digit_conv
module tb_ssa_digit_conv;
    logic clk;
    logic rst_n;

    ssa_digit_conv_if #(.OP_W(8), .BUS_W(96)) bus ();

    ssa_digit_conv dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .conv_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         c [8];
        int         prod;
    } vec_t;

    vec_t tbl [5];
    int   n_checks;
    int   n_fail;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference convolution straight from the definition: digit-product sums by index.
    function automatic logic [95:0] model_coef(input logic [7:0] a, input logic [7:0] b);
        int c [8];
        logic [95:0] r;
        for (int k = 0; k < 8; k++) c[k] = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c[(i + j) % 8] += ((int'(a) >> (2 * i)) & 3) * ((int'(b) >> (2 * j)) & 3);
        r = '0;
        for (int k = 0; k < 8; k++) r[k*9 +: 9] = 9'(c[k]);
        return r;
    endfunction

    function automatic int merge(input logic [95:0] cb);
        int s;
        s = 0;
        for (int k = 0; k < 8; k++) s += int'(cb[k*9 +: 9]) * (1 << (2 * k));
        return s;
    endfunction

    task automatic run_vec(input int idx, input int hold);
        logic [95:0] exp_bus;
        int lat;
        exp_bus = '0;
        for (int k = 0; k < 8; k++) exp_bus[k*9 +: 9] = 9'(tbl[idx].c[k]);
        @(negedge clk);
        bus.a = tbl[idx].a;
        bus.b = tbl[idx].b;
        bus.in_valid = 1'b1;
        bus.out_ready = (hold == 0);
        chk("in_ready_idle", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency_edges", lat, 16);
        chk("coef", bus.coef, exp_bus);
        chk("coef_upper_zero", bus.coef[95:72], 0);
        chk("merged", merge(bus.coef), tbl[idx].prod);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.a = 8'hFF;
            bus.b = 8'hFF;
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_coef_stable", bus.coef, exp_bus);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_out_valid", bus.out_valid, 0);
        chk("post_hs_in_ready", bus.in_ready, 1);
        chk("post_hs_coef_hold", bus.coef, exp_bus);
    endtask

    initial begin
        logic [7:0] qa [$];
        logic [7:0] qb [$];
        logic [7:0] ra, rb;
        int sent, recv, cyc;

        n_checks = 0;
        n_fail   = 0;
        tbl[0] = '{a: 8'hFF, b: 8'hFF, c: '{9, 18, 27, 36, 27, 18, 9, 0}, prod: 65025};
        tbl[1] = '{a: 8'h1B, b: 8'h01, c: '{3, 2, 1, 0, 0, 0, 0, 0}, prod: 27};
        tbl[2] = '{a: 8'h00, b: 8'hA5, c: '{0, 0, 0, 0, 0, 0, 0, 0}, prod: 0};
        tbl[3] = '{a: 8'h0F, b: 8'h0F, c: '{9, 18, 9, 0, 0, 0, 0, 0}, prod: 225};
        tbl[4] = '{a: 8'h02, b: 8'h03, c: '{6, 0, 0, 0, 0, 0, 0, 0}, prod: 6};

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        #22;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_coef", bus.coef, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 3; v++) run_vec(v, 0);
        run_vec(4, 10);

        // Reset asserted while the 8th MAC is pending.
        @(negedge clk);
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("midop_busy", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_coef", bus.coef, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(3, 0);

        // Random traffic against the reference model and an in-order scoreboard.
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 20 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (bus.out_valid && bus.out_ready) begin
                if (qa.size() == 0) begin
                    chk("rand_spurious_result", 1, 0);
                end else begin
                    ra = qa.pop_front();
                    rb = qb.pop_front();
                    chk("rand_coef", bus.coef, model_coef(ra, rb));
                    chk("rand_merged", merge(bus.coef), int'(ra) * int'(rb));
                    recv++;
                end
            end
            if (sent < 20) begin
                bus.in_valid = ($urandom_range(0, 1) == 1);
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
                if (bus.in_valid && bus.in_ready) begin
                    qa.push_back(bus.a);
                    qb.push_back(bus.b);
                    sent++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        chk("rand_all_received", recv, 20);
        chk("rand_queue_empty", qa.size(), 0);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rand_no_extra", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
